// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the SEQ register-file write-back scheduler:
// icode constants, special register IDs and the scheduler state encoding.
package regfile_wb_sched_pkg;

  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2,
    NOP  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_wb_sched_dst_decode.sv
// Combinational icode/cnd/ra/rb to dst_e/dst_m mapping, shared with the
// pipelined write-back path.
module wb_dst_decode
  import regfile_wb_sched_pkg::*;
(
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ:               dst_e = cnd ? rb : RNONE;
      IIRMOVQ, IOPQ:         dst_e = rb;
      IMRMOVQ:               dst_m = ra;
      ICALL, IRET, IPUSHQ:   dst_e = RSP;
      IPOPQ: begin
        dst_e = RSP;
        dst_m = ra;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: serialises a retired instruction's E and M writes onto
// the single register-file write port. Optional: WB_SAME_DST_MERGE_EN.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_code,
  input  logic              cnd,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [DATA_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_m,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [3:0]        dec_e, dec_m;
  logic [3:0]        dst_e, dst_m;
  logic [DATA_W-1:0] val_e_q, val_m_q;
  logic              accept;
  logic              skip_e;

  wb_dst_decode u_dst_decode (
    .icode (in_code),
    .cnd   (cnd),
    .ra    (ra),
    .rb    (rb),
    .dst_e (dec_e),
    .dst_m (dec_m)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

`ifdef WB_SAME_DST_MERGE_EN
  // The M write lands on the same register last anyway, so the E write is dead.
  assign skip_e = (dec_e == dec_m);
`else
  assign skip_e = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; the latched
  // data is reset too, so wr_data is defined from the first cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dst_e   <= RNONE;
      dst_m   <= RNONE;
      val_e_q <= '0;
      val_m_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dst_e   <= dec_e;
        dst_m   <= dec_m;
        val_e_q <= val_e;
        val_m_q <= val_m;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_e != RNONE && !skip_e) state_nxt = WR_E;
          else if (dec_m != RNONE)       state_nxt = WR_M;
          else                           state_nxt = NOP;
        end
      end
      WR_E:    state_nxt = (dst_m != RNONE) ? WR_M : IDLE;
      WR_M:    state_nxt = IDLE;
      NOP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched fields.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = RNONE;
    wr_data = '0;
    done    = 1'b0;
    case (state)
      WR_E: begin
        wr_en   = 1'b1;
        wr_addr = dst_e;
        wr_data = val_e_q;
        done    = (dst_m == RNONE);
      end
      WR_M: begin
        wr_en   = 1'b1;
        wr_addr = dst_m;
        wr_data = val_m_q;
        done    = 1'b1;
      end
      NOP:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler for the SEQ processor's 15-entry, 64-bit register file, which has a single write port.
- Accepts one retired instruction's write-back request per handshake, decodes the destinations dst_e and dst_m from the instruction code, and sequences the resulting writes onto the one write port.
- Instructions that write both destinations (popq) take two write cycles; the E write goes first and the M write second, so the M write wins when both target the same register.
- Sits between the memory stage outputs (val_e, val_m) and the register file write port.

Parameters:
- DATA_W, 64, width of val_e, val_m and wr_data.
- RNONE, 4'hF, register ID meaning "no destination". This ID is never written.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  a write-back request is presented.
- in_ready  out  1  the scheduler can accept a request this cycle.
- in_code  in  4  instruction code (icode).
- cnd  in  1  condition flag, used only by cmovXX.
- ra  in  4  rA field.
- rb  in  4  rB field.
- val_e  in  DATA_W  ALU result.
- val_m  in  DATA_W  memory read result.
- wr_en  out  1  register file write strobe.
- wr_addr  out  4  write register ID.
- wr_data  out  DATA_W  write data.
- done  out  1  one-cycle pulse: the request's last write (or its no-op) completes this cycle.
- busy  out  1  the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - Latched dst_e and dst_m = RNONE; latched data = 0.
  - Outputs: wr_en=0, wr_addr=RNONE, wr_data=0, done=0, busy=0, in_ready=1 after release.
  - Asserting reset mid-sequence aborts the sequence. Any pending E or M write is dropped, and no done pulse is produced.
- Handshake:
  - in_ready = (state==IDLE).
  - A request is accepted on a rising edge with in_valid & in_ready.
  - Inputs are sampled only at accept. Later changes to the inputs have no effect.
- Destination decode at accept (any icode not listed gives dst_e=dst_m=RNONE):
  - icode 2: dst_e = cnd ? rb : RNONE.
  - icode 3, 6: dst_e = rb.
  - icode 5: dst_m = ra.
  - icode 8, 9, 10: dst_e = 4 (%rsp).
  - icode 11: dst_e = 4, dst_m = ra.
- FSM states: IDLE, WR_E, WR_M, NOP.
  - Accept: go to WR_E if dst_e!=RNONE; else WR_M if dst_m!=RNONE; else NOP.
  - WR_E: go to WR_M if dst_m!=RNONE, else IDLE.
  - WR_M: go to IDLE.
  - NOP: go to IDLE.
- Outputs (decoded from registered state and latched fields, no combinational path from inputs):
  - WR_E: wr_en=1, wr_addr=dst_e, wr_data=val_e.
  - WR_M: wr_en=1, wr_addr=dst_m, wr_data=val_m.
  - IDLE/NOP: wr_en=0, wr_addr=RNONE, wr_data=0.
- done: asserted in WR_M; in WR_E when no M write follows; and in NOP.
- Latency and throughput: the first write appears in the cycle after accept. Throughput is one request per 2 cycles (single write) or 3 cycles (popq).
- A latched destination equal to RNONE never produces wr_en, including rb=0xF on icode 3 or 6.
- Same-destination case: for icode 11 with ra==4, both writes target %rsp and the final register value is val_m.
- in_valid held with no accept: the request waits, and nothing is latched.

Optional Feature:
- Macro: WB_SAME_DST_MERGE_EN.
- Defined: when dst_e==dst_m!=RNONE, the E write is skipped and accept goes directly to WR_M. popq %rsp then takes one write cycle.
- Not defined: the E write is always issued, giving the two-cycle sequence above. Final register contents are identical either way.

Decomposition:
- Shared package: icode constants (IRRMOVQ=2, IIRMOVQ=3, IMRMOVQ=5, IOPQ=6, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11), RSP=4, RNONE=4'hF, and the state enumeration.
- One natural sub-module: wb_dst_decode, a combinational icode/cnd/ra/rb to dst_e/dst_m mapping that the pipelined version will reuse. The FSM and output logic stay in the top.

Test Plan:
- Reset then idle: after rst_n release, expect in_ready=1, wr_en=0, wr_addr=F, done=0. Assert rst_n=0 during WR_E of a popq: expect outputs reset immediately and no WR_M cycle afterwards.
- OPq: icode=6, rb=3, val_e=0x1234 → next cycle wr_en=1, wr_addr=3, wr_data=0x1234, done=1; then IDLE.
- cmov: icode=2, rb=5, cnd=0 → NOP cycle with done=1 and wr_en=0. Same request with cnd=1 and val_e=0xAA → reg 5 written with 0xAA.
- popq: icode=11, ra=7, val_e=0x100, val_m=0xBEEF → cycle 1 writes addr 4 = 0x100; cycle 2 writes addr 7 = 0xBEEF with done=1; in_ready=0 for both cycles.
- popq %rsp: ra=4, val_e=0x108, val_m=0x55 → final write is 4=0x55. With WB_SAME_DST_MERGE_EN, exactly one write cycle (4=0x55).
- Back-to-back: in_valid held high over pushq (val_e=0xF8) then mrmovq (ra=2, val_m=0x9) → writes 4=0xF8 then 2=0x9, with one accept per return to IDLE and no request lost.
